core_ctrl: RTL and testbench
============================

Name: core_ctrl

Overview:
- Multi-cycle sequencing FSM for the RV64I core: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
- Consumes the instruction decoder's OPCODE/FUNCT3/FUNCT7 fields.
- Drives instruction-register load, PC update, register-file write, ALU operand/op selects and the instruction/data memory request handshakes.
- Owns a bus-timeout counter and the halt/trap status.

Parameters:
TIMEOUT_W, 8, width of memory wait counter
TIMEOUT_MAX, 255, cycles a req may wait for ready before bus error (1..2^TIMEOUT_W-1)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  decoder OPCODE
funct3  in  3  decoder FUNCT3
funct7  in  7  decoder FUNCT7
branch_taken  in  1  branch comparator result, valid in EXEC
imem_ready  in  1  instruction fetch complete
dmem_ready  in  1  data access complete
imem_req  out  1  instruction fetch request
ir_we  out  1  load instruction register
pc_we  out  1  write PC
pc_sel  out  2  next-PC source
rf_we  out  1  register-file write enable
wb_sel  out  2  write-back source
alu_a_sel  out  1  0=rs1, 1=PC
alu_b_sel  out  1  0=rs2, 1=IMM
alu_op  out  4  ALU operation
dmem_req  out  1  data request
dmem_we  out  1  1=store
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  sticky: EBREAK/ECALL reached
trap  out  1  sticky: illegal opcode or bus timeout
trap_cause  out  2  0=none, 1=illegal, 2=imem timeout, 3=dmem timeout

Behaviour:
- Single clock domain, clk; reset is asynchronous and active-low (rst_n).
- rst_n low: state=BOOT; wait counter=0; halted=0; trap=0; trap_cause=0. All strobes (imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we, retire) are 0 immediately. Selects are 0.
- Reset mid-operation aborts any outstanding request with no handshake cleanup. Memories must tolerate a dropped req.
- Outputs are combinational from state plus inputs. State, counter and status are registered.
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- BOOT: no outputs; next cycle -> FETCH.
- FETCH:
  - imem_req=1, held until imem_ready.
  - Cycle with imem_ready: ir_we=1 -> DECODE; counter cleared.
  - Counter increments each waiting cycle. If it reaches TIMEOUT_MAX without ready -> TRAP, cause 2.
- DECODE: one cycle for decoder/regfile to settle; no strobes; -> EXEC.
- EXEC, by opcode:
  - 0110011 OP: alu_op={funct7[5],funct3}, a=rs1, b=rs2 -> WB.
  - 0010011 OP-IMM: b=IMM. alu_op={funct3==101 ? funct7[5] : 0, funct3} -> WB.
  - 0110111 LUI -> WB.
  - 0010111 AUIPC: a=PC, b=IMM, alu_op=ADD -> WB.
  - 1101111 JAL and 1100111 JALR: -> WB.
  - 0000011 LOAD / 0100011 STORE: a=rs1, b=IMM, alu_op=ADD -> MEM.
  - 1100011 BRANCH: pc_we=1; pc_sel=BRANCH if branch_taken, else PC4; retire=1 -> FETCH.
  - 1110011 SYSTEM: halted=1 -> HALT.
  - Any other opcode: trap=1, cause 1 -> TRAP.
- MEM:
  - dmem_req=1 (dmem_we=1 for STORE) held stable until dmem_ready. Address ALU selects are held.
  - On ready: STORE gives pc_we=1, pc_sel=PC4, retire=1 -> FETCH. LOAD -> WB.
  - Timeout as in FETCH -> TRAP, cause 3.
- WB: rf_we=1, pc_we=1, retire=1 -> FETCH. Per opcode:
  - OP/OP-IMM/AUIPC: wb_sel=ALU, pc_sel=PC4.
  - LOAD: wb_sel=MEM, pc_sel=PC4.
  - LUI: wb_sel=IMM, pc_sel=PC4.
  - JAL: wb_sel=PC4, pc_sel=JAL.
  - JALR: wb_sel=PC4, pc_sel=JALR.
- Decoder fields are stable DECODE..WB because the IR is written only in FETCH. The FSM does not re-latch them.
- HALT and TRAP are terminal: no strobes, and only rst_n exits.
- Ready asserted in the same cycle as the first req is accepted: zero-wait access.
- Ready while not requesting is ignored.
- A timeout reached in the same cycle ready arrives: ready wins.

Decomposition:
- Package core_pkg holds:
  - state encoding;
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM);
  - pc_sel: PC4=0, BRANCH=1, JAL=2, JALR=3;
  - wb_sel: ALU=0, MEM=1, PC4=2, IMM=3;
  - alu_op: ADD=0000, SUB=1000, SRA=1101, others {0,funct3};
  - trap_cause codes.
- Optional sub-module mem_wait_timer: counter with clear/enable/expired, shared by FETCH and MEM.

Test Plan:
- Reset then fetch 0x002080b3 (add x1,x1,x2), imem_ready on 1st req cycle -> ir_we, then DECODE, EXEC alu_op=0000, then WB with rf_we=1, wb_sel=0, retire=1. Total 4 cycles from FETCH entry.
- 0x00832383 (lw) with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles, then WB wb_sel=1, rf_we=1.
- 0x00942623 (sw) -> MEM with dmem_we=1; on ready pc_we=1, pc_sel=0, rf_we never asserted.
- 0x00b50863 (beq): branch_taken=1 -> pc_sel=1; branch_taken=0 -> pc_sel=0. Both cases give retire=1 and rf_we=0.
- 0x00100073 (ebreak) -> halted=1 sticky, no imem_req afterward. Instr 0x00000000 -> trap=1, trap_cause=1.
- imem_ready held 0 -> TRAP, cause 2, after 255 wait cycles. Assert rst_n=0 mid-MEM -> dmem_req drops asynchronously, FSM reaches BOOT then FETCH.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the RV64I multi-cycle sequencer: FSM states, opcode
// classes, next-PC / write-back select codes, ALU op codes and trap causes.
package core_pkg;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_SEL_PC4    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JAL    = 2'd2;
  localparam logic [1:0] PC_SEL_JALR   = 2'd3;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_IMM = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1101;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  typedef struct packed {
    logic       a_sel;
    logic       b_sel;
    logic [3:0] op;
  } alu_ctrl_t;

  // ALU operand/op selection for an opcode class. Only OP, OP-IMM, AUIPC and
  // the address computation of LOAD/STORE use the ALU; everything else gets 0.
  function automatic alu_ctrl_t alu_ctrl(input logic [6:0] opcode,
                                         input logic [2:0] funct3,
                                         input logic       funct7_b5);
    alu_ctrl_t c;
    c = '0;
    case (opcode)
      // funct7[5] picks SUB/SRA variants: {funct7[5], funct3}
      OPC_OP:     c.op = funct7_b5 ? (ALU_SUB | {1'b0, funct3}) : {1'b0, funct3};
      // immediate forms only honour funct7[5] for the shift-right pair
      OPC_OP_IMM: begin
        c.b_sel = 1'b1;
        c.op    = (funct7_b5 && funct3 == 3'b101) ? ALU_SRA : {1'b0, funct3};
      end
      OPC_AUIPC: begin
        c.a_sel = 1'b1;
        c.b_sel = 1'b1;
        c.op    = ALU_ADD;
      end
      OPC_LOAD, OPC_STORE: begin
        c.b_sel = 1'b1;
        c.op    = ALU_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/core_ctrl_mem_wait_timer.sv
// Wait-cycle counter shared by instruction fetch and data access. Counts the
// cycles a request has been pending; expired_o flags the cycle in which the
// count would reach TIMEOUT_MAX while still waiting.
module core_ctrl_mem_wait_timer #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT_MAX - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Next count: cleared whenever not waiting, otherwise one more wait cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait-cycle register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current waiting cycle is the TIMEOUT_MAX-th one.
  assign expired_o = en_i && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer for the RV64I core:
// BOOT -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH, plus terminal
// HALT/TRAP. Strobes and selects are combinational from state and inputs;
// state, wait counter and halt/trap status are registered.
module core_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic [3:0] alu_op,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       retire,
  output logic       halted,
  output logic       trap,
  output logic [1:0] trap_cause
);

  state_e    state_q, state_d;
  logic      halted_q, halted_d;
  logic      trap_q, trap_d;
  logic [1:0] cause_q, cause_d;
  logic      waiting;
  logic      expired;
  alu_ctrl_t alu_sel;
  logic      unused_funct7;

  // Only funct7[5] matters to the sequencer.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Decoder fields are stable from DECODE through WB, so the ALU selects can
  // be derived directly from them in every state that needs them.
  assign alu_sel = alu_ctrl(opcode, funct3, funct7[5]);

  // A request is pending without its ready: this is a wait cycle.
  assign waiting = (state_q == ST_FETCH && !imem_ready) ||
                   (state_q == ST_MEM   && !dmem_ready);

  core_ctrl_mem_wait_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .TIMEOUT_MAX(TIMEOUT_MAX)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!waiting),
    .en_i     (waiting),
    .expired_o(expired)
  );

  // Next-state, status update and all strobes/selects. Ready is tested before
  // the timeout so a handshake in the expiry cycle still completes.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PC4;
    rf_we     = 1'b0;
    wb_sel    = WB_SEL_ALU;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          trap_d  = 1'b1;
          cause_d = CAUSE_IMEM_TO;
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_a_sel = alu_sel.a_sel;
        alu_b_sel = alu_sel.b_sel;
        alu_op    = alu_sel.op;
        case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
            state_d = ST_WB;
          OPC_LOAD, OPC_STORE:
            state_d = ST_MEM;
          OPC_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? PC_SEL_BRANCH : PC_SEL_PC4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          OPC_SYSTEM: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            trap_d  = 1'b1;
            cause_d = CAUSE_ILLEGAL;
            state_d = ST_TRAP;
          end
        endcase
      end
      ST_MEM: begin
        alu_a_sel = alu_sel.a_sel;
        alu_b_sel = alu_sel.b_sel;
        alu_op    = alu_sel.op;
        dmem_req  = 1'b1;
        dmem_we   = (opcode == OPC_STORE);
        if (dmem_ready) begin
          if (opcode == OPC_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_SEL_PC4;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (expired) begin
          trap_d  = 1'b1;
          cause_d = CAUSE_DMEM_TO;
          state_d = ST_TRAP;
        end
      end
      ST_WB: begin
        alu_a_sel = alu_sel.a_sel;
        alu_b_sel = alu_sel.b_sel;
        alu_op    = alu_sel.op;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        case (opcode)
          OPC_LOAD: wb_sel = WB_SEL_MEM;
          OPC_LUI:  wb_sel = WB_SEL_IMM;
          OPC_JAL: begin
            wb_sel = WB_SEL_PC4;
            pc_sel = PC_SEL_JAL;
          end
          OPC_JALR: begin
            wb_sel = WB_SEL_PC4;
            pc_sel = PC_SEL_JALR;
          end
          default: wb_sel = WB_SEL_ALU;
        endcase
        state_d = ST_FETCH;
      end
      ST_HALT, ST_TRAP: state_d = state_q;
      default: state_d = ST_BOOT;
    endcase
  end

  // State and sticky status registers; reset aborts any pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      halted_q <= 1'b0;
      trap_q   <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
    end
  end

  assign halted     = halted_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl. An instruction-level model expands each
// instruction into its expected per-cycle output trace; every cycle is
// compared at the falling edge, plus literal pins on key cycles.
module tb_core_ctrl;

  localparam int TO_MAX = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       branch_taken = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel;
  logic       dmem_req, dmem_we, retire, halted, trap;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [3:0] alu_op;

  core_ctrl #(.TIMEOUT_W(8), .TIMEOUT_MAX(TO_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we), .retire(retire),
    .halted(halted), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       a;
    logic       b;
    logic [3:0] op;
    logic       dmem_req;
    logic       dmem_we;
    logic       retire;
    logic       halted;
    logic       trap;
    logic [1:0] cause;
  } obs_t;

  obs_t act;
  assign act = {imem_req, ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_a_sel, alu_b_sel,
                alu_op, dmem_req, dmem_we, retire, halted, trap, trap_cause};

  int    checks = 0;
  int    errors = 0;
  string cur = "boot";
  obs_t  trace[$];
  bit    exp_halted = 0;
  bit    exp_trap = 0;
  logic [1:0] exp_cause = 2'd0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, a, r, $time);
    end
  endtask

  function automatic obs_t idle();
    obs_t o;
    o = '0;
    o.halted = exp_halted;
    o.trap   = exp_trap;
    o.cause  = exp_cause;
    return o;
  endfunction

  // ALU selects the instruction class calls for: {a_sel, b_sel, op}
  function automatic logic [5:0] model_alu(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return {2'b00, ins[30], ins[14:12]};
      7'b0010011: return (ins[14:12] == 3'b101) ? {2'b01, ins[30], 3'b101}
                                                 : {2'b01, 1'b0, ins[14:12]};
      7'b0010111: return 6'b11_0000;
      7'b0000011, 7'b0100011: return 6'b01_0000;
      default: return 6'b00_0000;
    endcase
  endfunction

  // One clock cycle: drive inputs after the rising edge, compare at falling edge.
  task automatic cyc(input obs_t e, input bit ir, input bit dr, input bit bt);
    @(posedge clk);
    #1;
    imem_ready   = ir;
    dmem_ready   = dr;
    branch_taken = bt;
    @(negedge clk);
    trace.push_back(act);
    chk({cur, "_cycle"}, 32'(act), 32'(e));
  endtask

  // Called at a falling edge; asserts reset asynchronously and releases it.
  task automatic apply_reset();
    #1;
    rst_n = 1'b0;
    exp_halted = 0;
    exp_trap = 0;
    exp_cause = 2'd0;
    #1;
    chk("reset_outputs", 32'(act), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    chk("boot_outputs", 32'(act), 32'(idle()));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(idle(), 1'b1, 1'b1, 1'b1);
  endtask

  // Expected trace of one instruction. iwait/dwait are cycles of held-off
  // ready; abort_mem>0 returns after that many MEM wait cycles.
  task automatic run_instr(input string name, input logic [31:0] ins, input int iwait,
                           input int dwait, input bit bt, input int abort_mem);
    obs_t e;
    logic [6:0] opc;
    logic [5:0] alu;
    cur = name;
    trace.delete();
    opc = ins[6:0];
    alu = model_alu(ins);
    for (int i = 0; i < iwait; i++) begin
      e = idle(); e.imem_req = 1'b1;
      cyc(e, 1'b0, 1'b0, 1'b0);
      if (i + 1 == TO_MAX) begin
        exp_trap = 1; exp_cause = 2'd2;
        return;
      end
    end
    e = idle(); e.imem_req = 1'b1; e.ir_we = 1'b1;
    cyc(e, 1'b1, 1'b0, 1'b0);
    opcode = ins[6:0]; funct3 = ins[14:12]; funct7 = ins[31:25];
    cyc(idle(), 1'b1, 1'b1, 1'b1);
    e = idle(); {e.a, e.b, e.op} = alu;
    case (opc)
      7'b1100011: begin
        e.pc_we = 1'b1; e.retire = 1'b1; e.pc_sel = bt ? 2'd1 : 2'd0;
        cyc(e, 1'b0, 1'b0, bt);
        return;
      end
      7'b1110011: begin
        cyc(e, 1'b0, 1'b0, bt);
        exp_halted = 1;
        return;
      end
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
      7'b0000011, 7'b0100011: cyc(e, 1'b0, 1'b0, bt);
      default: begin
        cyc(e, 1'b0, 1'b0, bt);
        exp_trap = 1; exp_cause = 2'd1;
        return;
      end
    endcase
    if (opc == 7'b0000011 || opc == 7'b0100011) begin
      e = idle(); {e.a, e.b, e.op} = alu;
      e.dmem_req = 1'b1; e.dmem_we = (opc == 7'b0100011);
      for (int i = 0; i < dwait; i++) begin
        cyc(e, 1'b0, 1'b0, 1'b0);
        if (abort_mem > 0 && i + 1 == abort_mem) return;
        if (i + 1 == TO_MAX) begin
          exp_trap = 1; exp_cause = 2'd3;
          return;
        end
      end
      if (opc == 7'b0100011) begin
        e.pc_we = 1'b1; e.pc_sel = 2'd0; e.retire = 1'b1;
        cyc(e, 1'b0, 1'b1, 1'b0);
        return;
      end
      cyc(e, 1'b0, 1'b1, 1'b0);
    end
    e = idle(); {e.a, e.b, e.op} = alu;
    e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
    case (opc)
      7'b0000011: e.wb_sel = 2'd1;
      7'b0110111: e.wb_sel = 2'd3;
      7'b1101111: begin e.wb_sel = 2'd2; e.pc_sel = 2'd2; end
      7'b1100111: begin e.wb_sel = 2'd2; e.pc_sel = 2'd3; end
      default:    e.wb_sel = 2'd0;
    endcase
    cyc(e, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int count_rf_we();
    int n = 0;
    foreach (trace[i]) n += int'(trace[i].rf_we);
    return n;
  endfunction

  function automatic int count_req(input bit dmem);
    int n = 0;
    foreach (trace[i]) n += dmem ? int'(trace[i].dmem_req) : int'(trace[i].imem_req);
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    apply_reset();

    run_instr("add", 32'h002080b3, 0, 0, 1'b0, 0);
    chk("add_cycles", trace.size(), 4);
    chk("add_exec_alu_op", 32'(trace[2].op), 32'h0);
    chk("add_wb_rf_we", 32'(trace[3].rf_we), 32'd1);
    chk("add_wb_sel", 32'(trace[3].wb_sel), 32'd0);
    chk("add_retire", 32'(trace[3].retire), 32'd1);

    run_instr("lw", 32'h00832383, 1, 3, 1'b0, 0);
    chk("lw_dmem_req_cycles", count_req(1'b1), 4);
    chk("lw_mem_we", 32'(trace[4].dmem_we), 32'd0);
    chk("lw_wb_sel", 32'(trace[8].wb_sel), 32'd1);
    chk("lw_wb_rf_we", 32'(trace[8].rf_we), 32'd1);

    run_instr("sw", 32'h00942623, 0, 2, 1'b0, 0);
    chk("sw_dmem_we", 32'(trace[3].dmem_we), 32'd1);
    chk("sw_ready_pc_we", 32'(trace[5].pc_we), 32'd1);
    chk("sw_ready_pc_sel", 32'(trace[5].pc_sel), 32'd0);
    chk("sw_no_rf_we", count_rf_we(), 0);

    run_instr("beq_taken", 32'h00b50863, 0, 0, 1'b1, 0);
    chk("beq_t_pc_sel", 32'(trace[2].pc_sel), 32'd1);
    chk("beq_t_retire", 32'(trace[2].retire), 32'd1);
    chk("beq_t_no_rf_we", count_rf_we(), 0);
    run_instr("beq_not", 32'h00b50863, 2, 0, 1'b0, 0);
    chk("beq_n_pc_sel", 32'(trace[4].pc_sel), 32'd0);
    chk("beq_n_retire", 32'(trace[4].retire), 32'd1);
    chk("beq_n_no_rf_we", count_rf_we(), 0);

    run_instr("sub", 32'h402081b3, 0, 0, 1'b0, 0);
    chk("sub_alu_op", 32'(trace[2].op), 32'h8);
    run_instr("srai", 32'h4030d093, 0, 0, 1'b0, 0);
    chk("srai_alu_op", 32'(trace[2].op), 32'hd);
    run_instr("addi_neg", 32'hc0000093, 0, 0, 1'b0, 0);
    chk("addi_neg_alu_op", 32'(trace[2].op), 32'h0);
    run_instr("lui", 32'h000012b7, 0, 0, 1'b0, 0);
    chk("lui_wb_sel", 32'(trace[3].wb_sel), 32'd3);
    run_instr("auipc", 32'h00000297, 1, 0, 1'b0, 0);
    run_instr("jal", 32'h008000ef, 0, 0, 1'b0, 0);
    chk("jal_pc_sel", 32'(trace[3].pc_sel), 32'd2);
    run_instr("jalr", 32'h000080e7, 0, 0, 1'b0, 0);
    chk("jalr_pc_sel", 32'(trace[3].pc_sel), 32'd3);

    // ready on the last permitted wait cycle completes normally
    run_instr("add_late", 32'h002080b3, TO_MAX - 1, 0, 1'b0, 0);
    chk("late_fetch_ir_we", 32'(trace[TO_MAX - 1].ir_we), 32'd1);
    run_instr("lw_late", 32'h00832383, 0, TO_MAX - 1, 1'b0, 0);
    chk("late_mem_rf_we", 32'(trace[trace.size() - 1].rf_we), 32'd1);

    run_instr("ebreak", 32'h00100073, 0, 0, 1'b0, 0);
    idle_cycles(4);
    chk("ebreak_halted", 32'(halted), 32'd1);
    chk("ebreak_no_imem_req", 32'(imem_req), 32'd0);
    apply_reset();

    run_instr("illegal", 32'h00000000, 0, 0, 1'b0, 0);
    idle_cycles(3);
    chk("illegal_trap", 32'(trap), 32'd1);
    chk("illegal_cause", 32'(trap_cause), 32'd1);
    apply_reset();

    run_instr("imem_to", 32'h002080b3, 300, 0, 1'b0, 0);
    chk("imem_to_req_cycles", count_req(1'b0), TO_MAX);
    cur = "imem_to_after";
    idle_cycles(3);
    chk("imem_to_cause", 32'(trap_cause), 32'd2);
    apply_reset();

    run_instr("dmem_to", 32'h00942623, 0, 300, 1'b0, 0);
    chk("dmem_to_req_cycles", count_req(1'b1), TO_MAX);
    cur = "dmem_to_after";
    idle_cycles(3);
    chk("dmem_to_cause", 32'(trap_cause), 32'd3);
    apply_reset();

    run_instr("lw_abort", 32'h00832383, 0, 10, 1'b0, 2);
    chk("abort_pre_dmem_req", 32'(dmem_req), 32'd1);
    apply_reset();
    chk("abort_post_dmem_req", 32'(dmem_req), 32'd0);
    run_instr("add_after_abort", 32'h002080b3, 0, 0, 1'b0, 0);
    chk("recover_cycles", trace.size(), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
